// File: rtl/serial_adder_pkg.sv
// Shared definitions for the bit-serial adder: FSM state encodings.
package serial_adder_pkg;

   // 2'd3 is unused and falls back to IDLE in the next-state logic.
   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_SHIFT = 2'd1,
      S_DONE  = 2'd2
   } state_t;

endpackage

// File: rtl/full_adder.sv
// One-bit full adder cell: sum and carry of three input bits.
module full_adder (
   input  logic a_in,
   input  logic b_in,
   input  logic c_in,
   output logic sum_out,
   output logic car_out
);

   logic w_half;

   assign w_half  = a_in ^ b_in;
   assign sum_out = w_half ^ c_in;
   assign car_out = (a_in & b_in) | (c_in & w_half);

endmodule

// File: rtl/serial_adder.sv
// Bit-serial WIDTH-bit adder: feeds full_adder one bit pair per clock, LSB first,
// keeps the carry in a flip-flop and publishes sum/carry-out with a done strobe.
module serial_adder
   import serial_adder_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic             clk_in,
   input  logic             rst_n_in,
   input  logic             start_in,
   input  logic [WIDTH-1:0] a_in,
   input  logic [WIDTH-1:0] b_in,
   input  logic             c_in,
   output logic             busy_out,
   output logic             done_out,
   output logic [WIDTH-1:0] sum_out,
   output logic             car_out
);

   localparam int CNT_W = $clog2(WIDTH);

   state_t             r_state;
   state_t             w_state_nxt;
   logic [WIDTH-1:0]   r_a_sr;
   logic [WIDTH-1:0]   r_b_sr;
   // Only the upper WIDTH-1 bits of the sum shift register are ever read back;
   // the bit shifted out at the bottom is discarded, so it is not stored.
   logic [WIDTH-2:0]   r_sum_sr;
   logic               r_carry_q;
   logic [CNT_W-1:0]   r_cnt;
   logic [WIDTH-1:0]   r_sum;
   logic               r_car;
   logic               w_fa_sum;
   logic               w_fa_car;
   logic               w_last;
   logic [WIDTH-1:0]   w_sum_nxt;

   full_adder u_fa (
      .a_in    (r_a_sr[0]),
      .b_in    (r_b_sr[0]),
      .c_in    (r_carry_q),
      .sum_out (w_fa_sum),
      .car_out (w_fa_car)
   );

   assign w_last    = (r_cnt == CNT_W'(WIDTH - 1));
   assign w_sum_nxt = {w_fa_sum, r_sum_sr};

   // State register.
   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) r_state <= S_IDLE;
      else           r_state <= w_state_nxt;
   end

   // Next-state logic: IDLE -> SHIFT on start, SHIFT -> DONE on last bit, DONE -> IDLE.
   always_comb begin
      w_state_nxt = S_IDLE;
      case (r_state)
         S_IDLE:  w_state_nxt = start_in ? S_SHIFT : S_IDLE;
         S_SHIFT: w_state_nxt = w_last ? S_DONE : S_SHIFT;
         S_DONE:  w_state_nxt = S_IDLE;
         default: w_state_nxt = S_IDLE;
      endcase
   end

   // Datapath: operand capture, bit-serial shifting, carry and result registers.
   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         r_a_sr    <= '0;
         r_b_sr    <= '0;
         r_sum_sr  <= '0;
         r_carry_q <= 1'b0;
         r_cnt     <= '0;
         r_sum     <= '0;
         r_car     <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (start_in) begin
                  r_a_sr    <= a_in;
                  r_b_sr    <= b_in;
                  r_carry_q <= c_in;
                  r_cnt     <= '0;
               end
            end
            S_SHIFT: begin
               r_a_sr    <= {1'b0, r_a_sr[WIDTH-1:1]};
               r_b_sr    <= {1'b0, r_b_sr[WIDTH-1:1]};
               r_sum_sr  <= w_sum_nxt[WIDTH-1:1];
               r_carry_q <= w_fa_car;
               if (w_last) begin
                  // Results are published only once complete, never partially.
                  r_sum <= w_sum_nxt;
                  r_car <= w_fa_car;
               end else begin
                  r_cnt <= r_cnt + CNT_W'(1);
               end
            end
            default: ;
         endcase
      end
   end

   assign busy_out = (r_state != S_IDLE);
   assign done_out = (r_state == S_DONE);
   assign sum_out  = r_sum;
   assign car_out  = r_car;

endmodule

// File: tb/tb_serial_adder.sv
// Scoreboard bench for serial_adder (WIDTH = 8): stimulus pushes hand-computed
// results with their accept cycle, a monitor pops them on each done pulse.
module tb_serial_adder;

   localparam int W = 8;

   typedef struct {
      logic [W:0] exp;
      int         acc;
   } item_t;

   logic         clk;
   logic         rst_n;
   logic         start;
   logic [W-1:0] a;
   logic [W-1:0] b;
   logic         c;
   logic         busy;
   logic         done;
   logic [W-1:0] sum;
   logic         car;

   item_t q[$];
   int    cyc;
   int    n_chk;
   int    n_err;

   serial_adder #(.WIDTH(W)) dut (
      .clk_in   (clk),
      .rst_n_in (rst_n),
      .start_in (start),
      .a_in     (a),
      .b_in     (b),
      .c_in     (c),
      .busy_out (busy),
      .done_out (done),
      .sum_out  (sum),
      .car_out  (car)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Monitor: every done pulse must match the oldest outstanding expectation.
   always @(negedge clk) begin
      if (done === 1'b1) begin
         if (q.size() == 0) begin
            chk("unexpected_done", 32'd1, 32'd0);
         end else begin
            item_t it;
            it = q.pop_front();
            chk("sum", {24'd0, sum}, {24'd0, it.exp[W-1:0]});
            chk("car", {31'd0, car}, {31'd0, it.exp[W]});
            chk("latency", cyc - it.acc, W);
         end
      end
   end

   // Issue one start and record its expected result.
   task automatic do_add(input logic [W-1:0] ta, input logic [W-1:0] tb_,
                         input logic tc, input logic [W:0] texp);
      item_t it;
      @(negedge clk);
      a     = ta;
      b     = tb_;
      c     = tc;
      start = 1'b1;
      @(posedge clk);
      #1;
      it.exp = texp;
      it.acc = cyc;
      q.push_back(it);
      chk("busy_after_accept", {31'd0, busy}, 32'd1);
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic drain();
      for (int i = 0; i < 40 && q.size() != 0; i++) @(negedge clk);
      chk("drain_timeout", q.size(), 0);
      repeat (3) @(negedge clk);
      chk("idle_after_drain", {31'd0, busy}, 32'd0);
   endtask

   task automatic reset_check(input string tag);
      chk({tag, "_busy"}, {31'd0, busy}, 32'd0);
      chk({tag, "_done"}, {31'd0, done}, 32'd0);
      chk({tag, "_sum"},  {24'd0, sum},  32'd0);
      chk({tag, "_car"},  {31'd0, car},  32'd0);
   endtask

   initial begin
      item_t it;
      int k;
      n_chk = 0;
      n_err = 0;
      cyc   = 0;
      rst_n = 1'b0;
      start = 1'b0;
      a     = '0;
      b     = '0;
      c     = 1'b0;
      repeat (3) @(negedge clk);
      reset_check("reset");
      rst_n = 1'b1;

      do_add(8'h5A, 8'h3C, 1'b0, 9'h096);
      drain();
      do_add(8'hFF, 8'h01, 1'b0, 9'h100);
      drain();
      do_add(8'hFF, 8'hFF, 1'b1, 9'h1FF);
      drain();
      do_add(8'h80, 8'h7F, 1'b1, 9'h100);
      drain();

      // Start held high through SHIFT/DONE with new operands: only the next IDLE takes them.
      @(negedge clk);
      a     = 8'h12;
      b     = 8'h34;
      c     = 1'b0;
      start = 1'b1;
      @(posedge clk);
      #1;
      k      = cyc;
      it.exp = 9'h046;
      it.acc = k;
      q.push_back(it);
      @(negedge clk);
      a      = 8'h11;
      b      = 8'h22;
      it.exp = 9'h033;
      it.acc = k + W + 2;
      q.push_back(it);
      while (cyc < k + W + 2) @(posedge clk);
      #1;
      start = 1'b0;
      drain();

      // Reset three cycles into SHIFT aborts the add with no result or done pulse.
      @(negedge clk);
      a     = 8'h77;
      b     = 8'h11;
      c     = 1'b1;
      start = 1'b1;
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b0;
      #1;
      reset_check("abort");
      repeat (3) @(negedge clk);
      reset_check("abort_hold");
      rst_n = 1'b1;
      repeat (12) @(negedge clk);
      chk("abort_no_result", {24'd0, sum}, 32'd0);

      do_add(8'h01, 8'h01, 1'b0, 9'h002);
      drain();

      $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_err);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "watchdog expired");
   end

endmodule
